// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencing (PC/IF-ID enables, stage flushes, halt drain) plus perf counters.
//   in : clk, CLR (sync reset), run, halt_req, redirect, ex_mem_read, ex_rd, id_rs, id_rt, id_rs_used, id_rt_used
//   out: pc_en, ifid_en, ifid_flush, idex_flush, halted, cycle_cnt, stall_cnt, flush_cnt
module fetch_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             run,
  input  logic             halt_req,
  input  logic             redirect,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;
  state_t     state, state_nxt;
  logic [3:0] dcnt, dcnt_nxt;
  logic       load_use, cyc_inc, stall_inc, flush_inc;
  assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                    ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b1;
    idex_flush = 1'b1;
    halted     = 1'b0;
    cyc_inc    = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    state_nxt  = state;
    dcnt_nxt   = dcnt;
    case (state)
      IDLE: state_nxt = run ? RUN : IDLE;
      RUN: begin
        cyc_inc = 1'b1;
        if (halt_req) begin
          idex_flush = 1'b0;
          state_nxt  = DRAIN;
          dcnt_nxt   = 4'(DRAIN_CYCLES - 1);
        end else if (redirect) begin
          pc_en     = 1'b1;
          ifid_en   = 1'b1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          ifid_flush = 1'b0;
          stall_inc  = 1'b1;
        end else begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b0;
          idex_flush = 1'b0;
        end
      end
      DRAIN: begin
        cyc_inc   = 1'b1;
        state_nxt = dcnt == 4'd0 ? HALT : DRAIN;
        dcnt_nxt  = dcnt == 4'd0 ? dcnt : dcnt - 4'd1;
      end
      HALT: begin
        halted    = 1'b1;
        state_nxt = run ? RUN : HALT;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (CLR) begin
      state     <= IDLE;
      dcnt      <= 4'd0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      cycle_cnt <= cycle_cnt + CNT_W'(cyc_inc);
      stall_cnt <= stall_cnt + CNT_W'(stall_inc);
      flush_cnt <= flush_cnt + CNT_W'(flush_inc);
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench with a behavioural model checked every cycle plus literal spot checks.
module tb_fetch_ctrl;
  localparam int DC = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;
  logic clk = 1'b0, clr, run, halt_req, redirect, ex_mem_read, id_rs_used, id_rt_used;
  logic [4:0] ex_rd, id_rs, id_rt;
  logic pc_en, ifid_en, ifid_flush, idex_flush, halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic p4, ie4, if4, xf4, h4;
  logic [3:0] cyc4, st4, fl4;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  int ms = M_IDLE, dleft = 0;
  logic [31:0] m_cyc = 0, m_stall = 0, m_flush = 0, held;
  logic e_pc, e_ifid, e_iff, e_xf, e_h, lu;
  always #5 clk = ~clk;
  fetch_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(32)) dut (
    .clk(clk), .CLR(clr), .run(run), .halt_req(halt_req), .redirect(redirect),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  fetch_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(4)) u4 (
    .clk(clk), .CLR(clr), .run(run), .halt_req(halt_req), .redirect(redirect),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .pc_en(p4), .ifid_en(ie4),
    .ifid_flush(if4), .idex_flush(xf4), .halted(h4),
    .cycle_cnt(cyc4), .stall_cnt(st4), .flush_cnt(fl4));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: expected outputs from mode and current inputs.
  always_comb begin
    lu = ex_mem_read && ex_rd != 0 && ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
    {e_pc, e_ifid, e_iff, e_xf, e_h} = 5'b00110;
    if (ms == M_HALT) e_h = 1'b1;
    if (ms == M_RUN) begin
      if (halt_req) {e_pc, e_ifid, e_iff, e_xf} = 4'b0010;
      else if (redirect) {e_pc, e_ifid, e_iff, e_xf} = 4'b1111;
      else if (lu) {e_pc, e_ifid, e_iff, e_xf} = 4'b0001;
      else {e_pc, e_ifid, e_iff, e_xf} = 4'b1100;
    end
  end
  always @(posedge clk) begin
    if (clr) begin
      ms <= M_IDLE; dleft <= 0; m_cyc <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      case (ms)
        M_IDLE: if (run) ms <= M_RUN;
        M_RUN: begin
          m_cyc <= m_cyc + 1;
          if (halt_req) begin ms <= M_DRAIN; dleft <= DC; end
          else if (redirect) m_flush <= m_flush + 1;
          else if (lu) m_stall <= m_stall + 1;
        end
        M_DRAIN: begin
          m_cyc <= m_cyc + 1;
          dleft <= dleft - 1;
          if (dleft == 1) ms <= M_HALT;
        end
        default: if (run) ms <= M_RUN;
      endcase
    end
  end
  always @(negedge clk) if (chk_en) begin
    check("pc_en", 32'(pc_en), 32'(e_pc));
    check("ifid_en", 32'(ifid_en), 32'(e_ifid));
    check("ifid_flush", 32'(ifid_flush), 32'(e_iff));
    check("idex_flush", 32'(idex_flush), 32'(e_xf));
    check("halted", 32'(halted), 32'(e_h));
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    check("u4_cycle_cnt", 32'(cyc4), m_cyc & 32'hf);
    check("u4_halted", 32'(h4), 32'(e_h));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet();
    {run, halt_req, redirect, ex_mem_read, id_rs_used, id_rt_used} = '0;
    {ex_rd, id_rs, id_rt} = '0;
  endtask
  initial begin
    quiet();
    clr = 1'b1;
    tick();
    chk_en = 1;
    tick();
    clr = 1'b0;
    #2;
    check("idle_pc_en", 32'(pc_en), 0);
    check("idle_ifid_flush", 32'(ifid_flush), 1);
    check("idle_cycle_cnt", cycle_cnt, 0);
    tick(); run = 1'b1;
    tick(); run = 1'b0; #2;
    check("run1_pc_en", 32'(pc_en), 1);
    check("run1_ifid_en", 32'(ifid_en), 1);
    tick(); #2;
    check("run1_cycle_cnt", cycle_cnt, 1);
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_rs_used = 1; #2;
    check("lu_pc_en", 32'(pc_en), 0);
    check("lu_ifid_en", 32'(ifid_en), 0);
    check("lu_idex_flush", 32'(idex_flush), 1);
    check("lu_stall_before", stall_cnt, 0);
    tick(); quiet(); #2;
    check("lu_stall_after", stall_cnt, 1);
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_rs_used = 1; #2;
    check("rd0_pc_en", 32'(pc_en), 1);
    tick(); quiet(); #2;
    check("rd0_stall", stall_cnt, 1);
    ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_rt_used = 1; #2;
    check("lu_rt_pc_en", 32'(pc_en), 0);
    tick(); quiet();
    ex_mem_read = 1; ex_rd = 9; id_rs = 9; id_rs_used = 0; #2;
    check("rs_unused_pc_en", 32'(pc_en), 1);
    check("lu_rt_stall", stall_cnt, 2);
    tick(); quiet();
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_rs_used = 1; redirect = 1; #2;
    check("lu_redir_pc_en", 32'(pc_en), 1);
    check("lu_redir_ifid_flush", 32'(ifid_flush), 1);
    check("lu_redir_idex_flush", 32'(idex_flush), 1);
    tick(); quiet(); #2;
    check("lu_redir_flush_cnt", flush_cnt, 1);
    check("lu_redir_stall_cnt", stall_cnt, 2);
    redirect = 1;
    tick(); quiet(); #2;
    check("redir_flush_cnt", flush_cnt, 2);
    halt_req = 1; redirect = 1; #2;
    check("halt_pc_en", 32'(pc_en), 0);
    check("halt_ifid_flush", 32'(ifid_flush), 1);
    check("halt_idex_flush", 32'(idex_flush), 0);
    tick(); quiet();
    for (int i = 0; i < DC; i++) begin
      halt_req = (i == 0); redirect = (i == 1); run = (i == 1); #2;
      check("drain_pc_en", 32'(pc_en), 0);
      check("drain_halted", 32'(halted), 0);
      tick(); quiet();
    end
    #2;
    check("halted_set", 32'(halted), 1);
    held = m_cyc;
    repeat (3) tick();
    #2;
    check("halt_cycle_frozen", cycle_cnt, held);
    run = 1; #2;
    check("halt_run_cycle", 32'(halted), 1);
    tick(); run = 0; #2;
    check("resume_halted", 32'(halted), 0);
    check("resume_pc_en", 32'(pc_en), 1);
    halt_req = 1;
    tick(); quiet();
    tick(); clr = 1;
    tick(); clr = 0; #2;
    check("clr_drain_halted", 32'(halted), 0);
    check("clr_drain_cycle", cycle_cnt, 0);
    check("clr_drain_stall", stall_cnt, 0);
    check("clr_drain_flush", flush_cnt, 0);
    check("clr_drain_pc_en", 32'(pc_en), 0);
    repeat (6) tick();
    #2;
    check("clr_no_halt", 32'(halted), 0);
    run = 1;
    tick(); run = 0;
    repeat (15) tick();
    #2;
    check("wrap_15", 32'(cyc4), 15);
    tick(); #2;
    check("wrap_0", 32'(cyc4), 0);
    check("wide_16", cycle_cnt, 16);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
